// File: rtl/cpu_pkg.sv
`default_nettype none
// ============================================================================
// Module      : cpu_pkg
// Description : Shared CPU constants: register file geometry and the fixed
//               writeback requester indices used by the writeback arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
package cpu_pkg;

    localparam int         REG_ADDR_W = 5;
    localparam int         XLEN       = 32;
    localparam logic [4:0] REG_ZERO   = 5'd0;

    // Writeback requester slots into the arbiter's request vector
    localparam int WB_SRC_ALU = 0;
    localparam int WB_SRC_LSU = 1;
    localparam int WB_SRC_MDU = 2;

endpackage : cpu_pkg
`default_nettype wire

// File: rtl/rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : rr_arbiter
// Description : Combinational round-robin arbiter. Searches the request
//               vector starting one past the last winner (rr_ptr_i) and
//               wrapping; returns a one-hot grant plus its binary index.
// Revision    : 1.0 - initial release
// ============================================================================
module rr_arbiter #(
    parameter int NUM_REQ = 3,
    parameter int IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic [NUM_REQ-1:0] req_i,
    input  logic [IDX_W-1:0]   rr_ptr_i,
    input  logic               enable_i,
    output logic [NUM_REQ-1:0] grant_o,
    output logic [IDX_W-1:0]   grant_idx_o
);

    // Walk offsets 1..NUM_REQ from the pointer; the first valid request wins
    always_comb begin
        int               sum;
        logic [IDX_W-1:0] cand;
        logic             found;
        grant_o     = '0;
        grant_idx_o = '0;
        found       = 1'b0;
        sum         = 0;
        cand        = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            sum  = (int'(rr_ptr_i) + k) % NUM_REQ;
            cand = IDX_W'(sum);
            if (enable_i && !found && req_i[cand]) begin
                found         = 1'b1;
                grant_o[cand] = 1'b1;
                grant_idx_o   = cand;
            end
        end
    end

endmodule : rr_arbiter
`default_nettype wire

// File: rtl/regfile_wb_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : regfile_wb_arbiter
// Description : Shares the register file write port between NUM_REQ
//               writeback sources. Round-robin grant, x0 write filtering,
//               a single registered write stage, and forwarding of the
//               in-flight write to the two decode read ports.
// Revision    : 1.0 - initial release
// ============================================================================
module regfile_wb_arbiter
    import cpu_pkg::*;
#(
    parameter int NUM_REQ = 3,
    parameter int DATA_W  = XLEN,
    parameter int ADDR_W  = REG_ADDR_W
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [NUM_REQ-1:0]        req_valid,
    input  logic [NUM_REQ*ADDR_W-1:0] req_rd,
    input  logic [NUM_REQ*DATA_W-1:0] req_data,
    output logic [NUM_REQ-1:0]        req_ready,
    input  logic                      hold,
    output logic                      rf_we,
    output logic [ADDR_W-1:0]         rf_rd_addr,
    output logic [DATA_W-1:0]         rf_wdata,
    input  logic [ADDR_W-1:0]         rs1_addr,
    input  logic [ADDR_W-1:0]         rs2_addr,
    output logic                      rs1_fwd_hit,
    output logic                      rs2_fwd_hit,
    output logic [DATA_W-1:0]         fwd_data,
    output logic                      busy
);

    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam logic [IDX_W-1:0] C_PTR_RESET = IDX_W'(NUM_REQ - 1);

    logic [IDX_W-1:0]   rr_ptr_q, rr_ptr_d;
    logic               rf_we_q, rf_we_d;
    logic [ADDR_W-1:0]  rd_addr_q, rd_addr_d;
    logic [DATA_W-1:0]  wdata_q, wdata_d;

    logic [NUM_REQ-1:0] w_grant;
    logic [IDX_W-1:0]   w_gnt_idx;
    logic               w_any_grant;
    logic [ADDR_W-1:0]  w_gnt_rd;
    logic [DATA_W-1:0]  w_gnt_data;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_rr_arbiter (
        .req_i       (req_valid),
        .rr_ptr_i    (rr_ptr_q),
        .enable_i    (!hold),
        .grant_o     (w_grant),
        .grant_idx_o (w_gnt_idx)
    );

    assign req_ready   = w_grant;
    assign w_any_grant = |w_grant;

    // One-hot select of the winning requester's destination and data
    always_comb begin
        w_gnt_rd   = '0;
        w_gnt_data = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (w_grant[i]) begin
                w_gnt_rd   = req_rd[i*ADDR_W +: ADDR_W];
                w_gnt_data = req_data[i*DATA_W +: DATA_W];
            end
        end
    end

    // Next-state: a grant loads the write stage (x0 accepted but not written),
    // otherwise the write strobe drops and address/data/pointer hold
    always_comb begin
        rr_ptr_d  = rr_ptr_q;
        rf_we_d   = 1'b0;
        rd_addr_d = rd_addr_q;
        wdata_d   = wdata_q;
        if (w_any_grant) begin
            rr_ptr_d  = w_gnt_idx;
            rf_we_d   = (w_gnt_rd != ADDR_W'(REG_ZERO));
            rd_addr_d = w_gnt_rd;
            wdata_d   = w_gnt_data;
        end
    end

    // Output write stage and round-robin pointer; reset drops any in-flight write
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rr_ptr_q  <= C_PTR_RESET;
            rf_we_q   <= 1'b0;
            rd_addr_q <= '0;
            wdata_q   <= '0;
        end else begin
            rr_ptr_q  <= rr_ptr_d;
            rf_we_q   <= rf_we_d;
            rd_addr_q <= rd_addr_d;
            wdata_q   <= wdata_d;
        end
    end

    assign rf_we      = rf_we_q;
    assign rf_rd_addr = rd_addr_q;
    assign rf_wdata   = wdata_q;

    // The register file commits one edge after rf_we, so decode reads of the
    // same register must take the in-flight value; x0 never forwards
    assign rs1_fwd_hit = rf_we_q && (rs1_addr == rd_addr_q) && (rs1_addr != '0);
    assign rs2_fwd_hit = rf_we_q && (rs2_addr == rd_addr_q) && (rs2_addr != '0);
    assign fwd_data    = wdata_q;

    assign busy = (|req_valid) | rf_we_q;

endmodule : regfile_wb_arbiter
`default_nettype wire
